// File: rtl/axi_lite_mem_bridge_if.sv
// AXI4-Lite bus bundle between the memory bridge (master) and the DDR3 interconnect (slave).
interface axi_lite_mem_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_lite_mem_bridge.sv
// Converts one start/drw request from the memory-control FSM into a single AXI4-Lite
// transaction and returns read data with a one-cycle done pulse.
module axi_lite_mem_bridge #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRB_W = DATA_W / 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_drw,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [STRB_W-1:0]     i_wstrb,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_done,
    output logic                  o_busy,
    output logic                  o_resp_err,
    axi_lite_mem_bridge_if.master m_axi
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWrResp,
        StRdAddr,
        StRdData,
        StDone
    } state_t;

    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic [STRB_W-1:0] r_wstrb, w_wstrb;
    logic              r_awvalid, w_awvalid;
    logic              r_wvalid, w_wvalid;
    logic              r_aw_ok, w_aw_ok;
    logic              r_w_ok, w_w_ok;
    logic              r_bready, w_bready;
    logic              r_arvalid, w_arvalid;
    logic              r_rready, w_rready;
    logic [DATA_W-1:0] r_rdata, w_rdata;
    logic              r_resp_err, w_resp_err;
    logic              r_done, w_done;
    logic              r_busy, w_busy;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    assign w_aw_hs = r_awvalid & m_axi.awready;
    assign w_w_hs  = r_wvalid  & m_axi.wready;
    assign w_b_hs  = r_bready  & m_axi.bvalid;
    assign w_ar_hs = r_arvalid & m_axi.arready;
    assign w_r_hs  = r_rready  & m_axi.rvalid;

    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_wstrb    = r_wstrb;
        w_awvalid  = r_awvalid;
        w_wvalid   = r_wvalid;
        w_aw_ok    = r_aw_ok;
        w_w_ok     = r_w_ok;
        w_bready   = r_bready;
        w_arvalid  = r_arvalid;
        w_rready   = r_rready;
        w_rdata    = r_rdata;
        w_resp_err = r_resp_err;
        w_done     = 1'b0;

        case (r_state)
            StIdle: begin
                // r_busy is still high during the done cycle, so a start there is dropped
                if (i_start && !r_busy) begin
                    w_addr  = i_addr;
                    w_wdata = i_wdata;
                    w_wstrb = i_wstrb;
                    if (i_drw) begin
                        w_state   = StWr;
                        w_awvalid = 1'b1;
                        w_wvalid  = 1'b1;
                        w_aw_ok   = 1'b0;
                        w_w_ok    = 1'b0;
                    end else begin
                        w_state   = StRdAddr;
                        w_arvalid = 1'b1;
                    end
                end
            end
            StWr: begin
                if (w_aw_hs) begin
                    w_awvalid = 1'b0;
                    w_aw_ok   = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid = 1'b0;
                    w_w_ok   = 1'b1;
                end
                if ((r_aw_ok || w_aw_hs) && (r_w_ok || w_w_hs)) begin
                    w_state  = StWrResp;
                    w_bready = 1'b1;
                end
            end
            StWrResp: begin
                if (w_b_hs) begin
                    w_resp_err = (m_axi.bresp != 2'b00);
                    w_bready   = 1'b0;
                    w_state    = StDone;
                end
            end
            StRdAddr: begin
                if (w_ar_hs) begin
                    w_arvalid = 1'b0;
                    w_rready  = 1'b1;
                    w_state   = StRdData;
                end
            end
            StRdData: begin
                if (w_r_hs) begin
                    w_rdata    = m_axi.rdata;
                    w_resp_err = (m_axi.rresp != 2'b00);
                    w_rready   = 1'b0;
                    w_state    = StDone;
                end
            end
            StDone: begin
                w_done  = 1'b1;
                w_state = StIdle;
            end
            default: begin
                w_state = StIdle;
            end
        endcase

        w_busy = (w_state != StIdle) || (r_state == StDone);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_aw_ok    <= 1'b0;
            r_w_ok     <= 1'b0;
            r_bready   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_rdata    <= '0;
            r_resp_err <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_wstrb    <= w_wstrb;
            r_awvalid  <= w_awvalid;
            r_wvalid   <= w_wvalid;
            r_aw_ok    <= w_aw_ok;
            r_w_ok     <= w_w_ok;
            r_bready   <= w_bready;
            r_arvalid  <= w_arvalid;
            r_rready   <= w_rready;
            r_rdata    <= w_rdata;
            r_resp_err <= w_resp_err;
            r_done     <= w_done;
            r_busy     <= w_busy;
        end
    end

    assign m_axi.awaddr  = r_addr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = r_wstrb;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.bready  = r_bready;
    assign m_axi.araddr  = r_addr;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = r_rready;

    assign o_rdata    = r_rdata;
    assign o_done     = r_done;
    assign o_busy     = r_busy;
    assign o_resp_err = r_resp_err;

endmodule

// File: tb/tb_axi_lite_mem_bridge.sv
// Bench: scripted AXI4-Lite slave with per-channel wait states and a scoreboard of expected
// transactions. Zero-wait latency from start-sampling edge to visible done is 4 cycles.
`timescale 1ns/1ps
module tb_axi_lite_mem_bridge;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          drw = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic [DW-1:0] rdata;
    logic          done;
    logic          busy;
    logic          resp_err;

    always #5 clk = ~clk;

    axi_lite_mem_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) bus ();

    axi_lite_mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_drw      (drw),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .i_wstrb    (wstrb),
        .o_rdata    (rdata),
        .o_done     (done),
        .o_busy     (busy),
        .o_resp_err (resp_err),
        .m_axi      (bus.master)
    );

    typedef struct {
        logic        drw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave configuration, set per transaction.
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  s_resp = 2'b00;
    logic [31:0] s_rdata = '0;

    // Slave and monitor state.
    int          cyc = 0;
    int          t_start = 0;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int          n_aw, n_w, n_ar, n_awv_cyc, n_wv_cyc;
    int          n_done = 0;
    bit          aw_seen, w_seen, ar_seen, b_pend, r_pend, b_fire, r_fire, b_started, r_started;
    bit          aw_stall, w_stall, ar_stall;
    logic [31:0] prev_awaddr, prev_wdata, prev_araddr;
    logic [31:0] last_rd = '0;
    logic        prev_done = 1'b0;
    exp_t        e_mon;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_txn();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        n_aw = 0; n_w = 0; n_ar = 0; n_awv_cyc = 0; n_wv_cyc = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; b_pend = 0; r_pend = 0;
        b_fire = 0; r_fire = 0; b_started = 0; r_started = 0;
        aw_stall = 0; w_stall = 0; ar_stall = 0;
    endtask

    // Slave decides READY/VALID at negedge; a VALID&READY seen here fires on the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
            bus.bvalid = 1'b0; bus.bresp = 2'b00;
            bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = '0;
            clear_txn();
            prev_done = 1'b0;
        end else begin
            if (bus.awvalid) begin
                n_awv_cyc++;
                if (aw_stall) check_eq("awaddr_stable", bus.awaddr, prev_awaddr);
                if (aw_cnt >= aw_wait) begin
                    bus.awready = 1'b1; aw_seen = 1; n_aw++; aw_stall = 0;
                    check_eq("aw_expected", exp_q.size() != 0 && exp_q[0].drw, 1);
                    if (exp_q.size() != 0) check_eq("awaddr", bus.awaddr, exp_q[0].addr);
                    check_eq("awprot", bus.awprot, 0);
                end else begin
                    bus.awready = 1'b0; aw_cnt++; aw_stall = 1; prev_awaddr = bus.awaddr;
                end
            end else begin
                bus.awready = 1'b0; aw_stall = 0;
            end

            if (bus.wvalid) begin
                n_wv_cyc++;
                if (w_stall) check_eq("wdata_stable", bus.wdata, prev_wdata);
                if (w_cnt >= w_wait) begin
                    bus.wready = 1'b1; w_seen = 1; n_w++; w_stall = 0;
                    check_eq("w_expected", exp_q.size() != 0 && exp_q[0].drw, 1);
                    if (exp_q.size() != 0) begin
                        check_eq("wdata", bus.wdata, exp_q[0].wdata);
                        check_eq("wstrb", bus.wstrb, exp_q[0].wstrb);
                    end
                end else begin
                    bus.wready = 1'b0; w_cnt++; w_stall = 1; prev_wdata = bus.wdata;
                end
            end else begin
                bus.wready = 1'b0; w_stall = 0;
            end

            if (bus.arvalid) begin
                if (ar_stall) check_eq("araddr_stable", bus.araddr, prev_araddr);
                if (ar_cnt >= ar_wait) begin
                    bus.arready = 1'b1; ar_seen = 1; n_ar++; ar_stall = 0;
                    check_eq("ar_expected", exp_q.size() != 0 && !exp_q[0].drw, 1);
                    if (exp_q.size() != 0) check_eq("araddr", bus.araddr, exp_q[0].addr);
                    check_eq("arprot", bus.arprot, 0);
                end else begin
                    bus.arready = 1'b0; ar_cnt++; ar_stall = 1; prev_araddr = bus.araddr;
                end
            end else begin
                bus.arready = 1'b0; ar_stall = 0;
            end

            if (b_fire) begin bus.bvalid = 1'b0; b_fire = 0; end
            if (b_pend) begin
                if (b_cnt >= b_wait) begin
                    bus.bvalid = 1'b1; bus.bresp = s_resp; b_pend = 0;
                end else b_cnt++;
            end
            if (bus.bready) check_eq("bready_after_aw_w", aw_seen && w_seen, 1);
            if (bus.bvalid && bus.bready) b_fire = 1;
            if (aw_seen && w_seen && !b_started) begin b_pend = 1; b_cnt = 0; b_started = 1; end

            if (r_fire) begin bus.rvalid = 1'b0; r_fire = 0; end
            if (r_pend) begin
                if (r_cnt >= r_wait) begin
                    bus.rvalid = 1'b1; bus.rdata = s_rdata; bus.rresp = s_resp; r_pend = 0;
                end else r_cnt++;
            end
            if (bus.rready) check_eq("rready_after_ar", ar_seen, 1);
            if (bus.rvalid && bus.rready) r_fire = 1;
            if (ar_seen && !r_started) begin r_pend = 1; r_cnt = 0; r_started = 1; end

            if (done) begin
                check_eq("done_single", prev_done, 0);
                check_eq("done_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e_mon = exp_q.pop_front();
                    check_eq("busy_at_done", busy, 1);
                    check_eq("resp_err", resp_err, e_mon.err);
                    check_eq("latency", cyc - t_start, e_mon.lat);
                    if (!e_mon.drw) last_rd = e_mon.rdata;
                    check_eq("rdata", rdata, last_rd);
                    check_eq("n_aw", n_aw, e_mon.drw ? 1 : 0);
                    check_eq("n_w", n_w, e_mon.drw ? 1 : 0);
                    check_eq("n_ar", n_ar, e_mon.drw ? 0 : 1);
                    if (e_mon.drw) begin
                        check_eq("awvalid_cycles", n_awv_cyc, aw_wait + 1);
                        check_eq("wvalid_cycles", n_wv_cyc, w_wait + 1);
                    end
                end
                n_done++;
                clear_txn();
            end
            prev_done = done;
        end
    end

    task automatic run_txn(input logic d, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic [31:0] rd, input logic [1:0] rs,
                           input int awt, input int wt, input int bt, input int art,
                           input int rt, input bit spur);
        exp_t e;
        int   base;
        bit   seen;
        aw_wait = awt; w_wait = wt; b_wait = bt; ar_wait = art; r_wait = rt;
        s_resp = rs; s_rdata = rd;
        e.drw = d; e.addr = a; e.wdata = wd; e.wstrb = ws; e.rdata = rd;
        e.err = (rs != 2'b00);
        e.lat = d ? 4 + ((awt > wt) ? awt : wt) + bt : 4 + art + rt;
        @(negedge clk); #1;
        exp_q.push_back(e);
        start = 1'b1; drw = d; addr = a; wdata = wd; wstrb = ws; t_start = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        base = n_done;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (spur && i >= 1) begin
                start = 1'b1; drw = 1'b1; addr = 32'h0000_0020; wdata = 32'hFFFF_FFFF;
            end
            @(negedge clk); #1;
            if (n_done != base) seen = 1;
        end
        check_eq("done_timeout", seen, 1);
        // a spurious start stays high across the done cycle and is dropped only after it
        @(negedge clk); #1;
        start = 1'b0;
        check_eq("busy_after", busy, 0);
        check_eq("idle_no_valid", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
    endtask

    task automatic reset_mid_read();
        exp_t e;
        bit   hit;
        int   base;
        ar_wait = 0; r_wait = 50; s_resp = 2'b00; s_rdata = 32'h7777_7777;
        e.drw = 1'b0; e.addr = 32'h40; e.wdata = '0; e.wstrb = '0;
        e.rdata = s_rdata; e.err = 1'b0; e.lat = 0;
        @(negedge clk); #1;
        exp_q.push_back(e);
        start = 1'b1; drw = 1'b0; addr = 32'h40; t_start = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (bus.rready) hit = 1;
            else begin @(negedge clk); #1; end
        end
        check_eq("reached_rd_data", hit, 1);
        base = n_done;
        rst = 1'b1;
        @(negedge clk); #1;
        check_eq("rst_valid_ready", {bus.awvalid, bus.wvalid, bus.bready,
                                     bus.arvalid, bus.rready}, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        exp_q.delete();
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check_eq("rst_no_done", n_done - base, 0);
        check_eq("rst_idle_busy", busy, 0);
    endtask

    initial begin
        clear_txn();
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_outs", {rdata, done, busy, resp_err}, 0);
        check_eq("reset_valid_ready", {bus.awvalid, bus.wvalid, bus.bready,
                                       bus.arvalid, bus.rready}, 0);
        check_eq("reset_buses", {bus.awaddr, bus.wdata, bus.wstrb, bus.araddr}, 0);
        rst = 1'b0;

        // d, addr, wdata, wstrb, rdata, resp, aw, w, b, ar, r waits, spurious start
        run_txn(1, 32'h10, 32'hCAFE_F00D, 4'hF, '0, 2'b00, 0, 0, 0, 0, 0, 0);
        run_txn(0, 32'h104, '0, '0, 32'h1234_5678, 2'b00, 0, 0, 0, 3, 2, 0);
        run_txn(1, 32'h14, 32'hA5A5_0102, 4'h3, '0, 2'b00, 4, 0, 0, 0, 0, 0);
        run_txn(0, 32'h200, '0, '0, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 0, 0, 0);
        check_eq("err_sticky", resp_err, 1);
        run_txn(1, 32'h18, 32'h0000_1111, 4'h1, '0, 2'b00, 0, 0, 0, 0, 0, 0);
        check_eq("err_cleared", resp_err, 0);
        run_txn(0, 32'h300, '0, '0, 32'h0BAD_F00D, 2'b00, 0, 0, 0, 1, 3, 1);
        reset_mid_read();
        run_txn(0, 32'h44, '0, '0, 32'h55AA_33CC, 2'b00, 0, 0, 0, 0, 0, 0);
        run_txn(1, 32'h48, 32'h0102_0304, 4'hC, '0, 2'b11, 0, 2, 1, 0, 0, 0);
        check_eq("decerr_flag", resp_err, 1);
        check_eq("rdata_held", rdata, 32'h55AA_33CC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
